// File: rtl/pci_bus_arbiter.sv
// Round-robin arbiter for a shared PCI-style bus: one active-low grant per device,
// idle detection from iframe/iready. Optional bus parking behind `PCI_ARB_PARK_EN.

module pci_bus_arbiter_checker #(
    parameter int N_MASTERS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic [N_MASTERS-1:0] grant,
    input logic                 grant_valid
);

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~grant));
    assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (grant != {N_MASTERS{1'b1}}));

endmodule

module pci_bus_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int OWNER_W     = 2,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] request,
    input  logic                 iframe,
    input  logic                 iready,
    output logic [N_MASTERS-1:0] grant,
    output logic [OWNER_W-1:0]   owner,
    output logic                 grant_valid,
    output logic                 bus_busy
);

    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [N_MASTERS-1:0] ALL_ONES = {N_MASTERS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    state_t               state_r;
    logic [OWNER_W-1:0]   last_owner_r;
    logic [7:0]           tmo_cnt_r;
`ifdef PCI_ARB_PARK_EN
    logic                 parked_r;
`endif

    logic [N_MASTERS-1:0] req_act_s;
    logic [N_MASTERS-1:0] last_mask_s;
    logic                 any_req_s;
    logic                 bus_idle_s;
    logic                 owner_req_s;
    logic                 other_req_s;
    logic                 tmo_hit_s;
    logic [OWNER_W-1:0]   winner_s;

    // First requester after 'last', wrapping; lowest rotation distance wins.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req_act,
                                                   input logic [OWNER_W-1:0]   last);
        logic [OWNER_W-1:0] idx;
        logic [OWNER_W-1:0] pick;
        pick = last;
        for (int k = N_MASTERS; k >= 1; k--) begin
            idx = OWNER_W'((int'(last) + k) % N_MASTERS);
            if ((req_act & (ONE_HOT0 << idx)) != {N_MASTERS{1'b0}}) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Request decode, bus-idle detection and round-robin winner.
    always_comb begin
        req_act_s   = ~request;
        any_req_s   = |req_act_s;
        bus_idle_s  = iframe & iready;
        last_mask_s = ONE_HOT0 << last_owner_r;
        owner_req_s = |(req_act_s & last_mask_s);
        other_req_s = |(req_act_s & ~last_mask_s);
        tmo_hit_s   = (tmo_cnt_r == 8'(GNT_TIMEOUT - 1));
        winner_s    = rr_pick(req_act_s, last_owner_r);
    end

    // Arbitration FSM with registered grant/owner/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant        <= ALL_ONES;
            owner        <= {OWNER_W{1'b0}};
            grant_valid  <= 1'b0;
            bus_busy     <= 1'b0;
            last_owner_r <= OWNER_W'(N_MASTERS - 1);
            tmo_cnt_r    <= 8'd0;
`ifdef PCI_ARB_PARK_EN
            parked_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                    if (parked_r) begin
                        if (!iframe) begin
                            state_r  <= ST_BUSY;
                            bus_busy <= 1'b1;
                            parked_r <= 1'b0;
                        end else if (other_req_s) begin
                            // Drop the park grant; the real arbitration follows next edge.
                            grant       <= ALL_ONES;
                            grant_valid <= 1'b0;
                            parked_r    <= 1'b0;
                        end else if (owner_req_s) begin
                            state_r   <= ST_GRANTED;
                            tmo_cnt_r <= 8'd0;
                            parked_r  <= 1'b0;
                        end else begin
                            parked_r <= 1'b1;
                        end
                    end else if (any_req_s && bus_idle_s) begin
                        grant        <= ~(ONE_HOT0 << winner_s);
                        owner        <= winner_s;
                        last_owner_r <= winner_s;
                        grant_valid  <= 1'b1;
                        tmo_cnt_r    <= 8'd0;
                        state_r      <= ST_GRANTED;
                    end else if (bus_idle_s) begin
                        grant       <= ~last_mask_s;
                        owner       <= last_owner_r;
                        grant_valid <= 1'b1;
                        parked_r    <= 1'b1;
                    end else begin
                        grant       <= ALL_ONES;
                        grant_valid <= 1'b0;
                    end
`else
                    if (any_req_s && bus_idle_s) begin
                        grant        <= ~(ONE_HOT0 << winner_s);
                        owner        <= winner_s;
                        last_owner_r <= winner_s;
                        grant_valid  <= 1'b1;
                        tmo_cnt_r    <= 8'd0;
                        state_r      <= ST_GRANTED;
                    end else begin
                        grant       <= ALL_ONES;
                        grant_valid <= 1'b0;
                    end
`endif
                end
                ST_GRANTED: begin
                    // iframe has priority over both release causes.
                    if (!iframe) begin
                        state_r   <= ST_BUSY;
                        bus_busy  <= 1'b1;
                        tmo_cnt_r <= 8'd0;
                    end else if (!owner_req_s || tmo_hit_s) begin
                        grant       <= ALL_ONES;
                        grant_valid <= 1'b0;
                        tmo_cnt_r   <= 8'd0;
                        state_r     <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_BUSY: begin
                    if (bus_idle_s) begin
                        grant       <= ALL_ONES;
                        grant_valid <= 1'b0;
                        bus_busy    <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (iframe) begin
                        grant       <= ALL_ONES;
                        grant_valid <= 1'b0;
                    end else begin
                        grant <= grant;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant       <= ALL_ONES;
                    grant_valid <= 1'b0;
                    bus_busy    <= 1'b0;
                end
            endcase
        end
    end

    pci_bus_arbiter_checker #(
        .N_MASTERS(N_MASTERS)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level reference model.

module tb_pci_bus_arbiter;

    localparam int N = 4;
    localparam int T = 16;
`ifdef PCI_ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] request;
    logic       iframe;
    logic       iready;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       grant_valid;
    logic       bus_busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who holds the grant, whether a transaction is running, etc.
    int m_gidx, m_owner, m_last, m_cnt;
    bit m_busy, m_tx, m_wait, m_parked;

    pci_bus_arbiter #(.N_MASTERS(4), .OWNER_W(2), .GNT_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .iframe(iframe), .iready(iready),
        .grant(grant), .owner(owner), .grant_valid(grant_valid), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit req_low(input logic [3:0] req, input int i);
        return req[2'(i)] == 1'b0;
    endfunction

    function automatic int pick(input logic [3:0] req, input int last);
        int found;
        found = -1;
        for (int k = 1; k <= N; k++) begin
            if (found < 0 && req_low(req, (last + k) % N)) found = (last + k) % N;
        end
        return found;
    endfunction

    task automatic model_update();
        int w;
        bit others;
        if (!rst_n) begin
            m_gidx = -1; m_owner = 0; m_last = N - 1; m_cnt = 0;
            m_busy = 0; m_tx = 0; m_wait = 0; m_parked = 0;
        end else if (m_tx) begin
            if (iframe && iready) begin m_tx = 0; m_busy = 0; m_gidx = -1; end
            else if (iframe) m_gidx = -1;
        end else if (m_wait) begin
            if (!iframe) begin m_tx = 1; m_busy = 1; m_wait = 0; end
            else if (!req_low(request, m_gidx) || m_cnt == T - 1) begin m_gidx = -1; m_wait = 0; end
            else m_cnt++;
        end else if (m_parked) begin
            others = 0;
            for (int j = 0; j < N; j++) if (j != m_last && req_low(request, j)) others = 1;
            if (!iframe) begin m_tx = 1; m_busy = 1; m_parked = 0; end
            else if (others) begin m_gidx = -1; m_parked = 0; end
            else if (req_low(request, m_last)) begin m_wait = 1; m_cnt = 0; m_parked = 0; end
        end else begin
            w = pick(request, m_last);
            if (w >= 0 && iframe && iready) begin
                m_gidx = w; m_owner = w; m_last = w; m_wait = 1; m_cnt = 0;
            end else if (PARK && w < 0 && iframe && iready) begin
                m_gidx = m_last; m_owner = m_last; m_parked = 1;
            end else m_gidx = -1;
        end
    endtask

    task automatic step();
        logic [3:0] eg;
        @(posedge clk);
        model_update();
        #1;
        eg = 4'hF;
        if (m_gidx >= 0) eg[2'(m_gidx)] = 1'b0;
        check("grant", {28'd0, grant}, {28'd0, eg});
        check("owner", {30'd0, owner}, 32'(m_owner));
        check("grant_valid", {31'd0, grant_valid}, {31'd0, m_gidx >= 0});
        check("bus_busy", {31'd0, bus_busy}, {31'd0, m_busy});
        check("onehot0", {31'd0, $onehot0(~grant)}, 32'd1);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (grant !== exp && n < 8) begin step(); n++; end
        check(tag, {28'd0, grant}, {28'd0, exp});
    endtask

    task automatic do_tx(input int len);
        iframe = 1'b0; iready = 1'b0;
        repeat (len) step();
        iframe = 1'b1; iready = 1'b0;
        step();
        iready = 1'b1;
        step();
    endtask

    initial begin
        int cnt, phase, left;
        logic [3:0] mask;

        // Reset with every request already low.
        rst_n = 1'b0; request = 4'b0000; iframe = 1'b1; iready = 1'b1;
        step();
        step();
        check("reset_grant", {28'd0, grant}, 32'hF);
        rst_n = 1'b1;
        step();
        check("first_grant", {28'd0, grant}, 32'hE);
        check("first_owner", {30'd0, owner}, 32'd0);

        // Round-robin 0,1,2,3,0 with one turnaround cycle each.
        for (int k = 1; k <= 4; k++) begin
            do_tx(3);
            check("turnaround", {28'd0, grant}, 32'hF);
            step();
            check("rr_order", {30'd0, owner}, 32'(k % 4));
        end
        request = 4'hF;
        step();

        // Master 2 alone never starts: grant held exactly T cycles.
        request = 4'b1011;
        wait_grant("tmo_grant", 4'b1011);
        cnt = 0;
        while (grant === 4'b1011 && cnt < 40) begin step(); cnt++; end
        check("tmo_cycles", 32'(cnt), 32'(T));
        check("tmo_release", {28'd0, grant}, 32'hF);
        request = 4'b1010;
        step();
        check("tmo_next_owner", {30'd0, owner}, 32'd0);
        do_tx(2);
        step();
        check("tmo_regrant2", {30'd0, owner}, 32'd2);
        request = 4'hF;
        step();

        // Master 1 withdraws before iframe.
        request = 4'b1101;
        wait_grant("m1_grant", 4'b1101);
        request = 4'hF;
        step();
        check("m1_release", {28'd0, grant}, 32'hF);
        check("m1_not_busy", {31'd0, bus_busy}, 32'd0);

        // No preemption of master 0 by master 3.
        request = 4'b1110;
        wait_grant("m0_grant", 4'b1110);
        iframe = 1'b0; iready = 1'b0;
        step();
        request = 4'b0111;
        step();
        step();
        check("no_preempt", {28'd0, grant}, 32'hE);
        iframe = 1'b1;
        step();
        check("final_phase_grant", {28'd0, grant}, 32'hF);
        check("final_phase_busy", {31'd0, bus_busy}, 32'd1);
        iready = 1'b1;
        step();
        check("idle_busy", {31'd0, bus_busy}, 32'd0);
        step();
        check("m3_grant", {28'd0, grant}, 32'h7);
        check("m3_owner", {30'd0, owner}, 32'd3);

`ifdef PCI_ARB_PARK_EN
        request = 4'b1101;
        wait_grant("park_m1_grant", 4'b1101);
        request = 4'hF;
        do_tx(3);
        step();
        check("park_grant", {28'd0, grant}, 32'hD);
        check("park_valid", {31'd0, grant_valid}, 32'd1);
        request = 4'b1011;
        step();
        check("park_drop", {28'd0, grant}, 32'hF);
        step();
        check("park_m2_grant", {28'd0, grant}, 32'hB);
`endif

        // Random traffic with a simple master emulator.
        request = 4'hF; iframe = 1'b1; iready = 1'b1;
        phase = 0; left = 0;
        for (int c = 0; c < 4000; c++) begin
            mask = 4'd0;
            for (int b = 0; b < N; b++) mask[2'(b)] = ($urandom_range(0, 7) == 0);
            request = request ^ mask;
            rst_n = ($urandom_range(0, 499) != 0);
            if (phase == 0 && m_gidx >= 0 && !m_tx && $urandom_range(0, 3) != 0) begin
                phase = 1;
                left = $urandom_range(1, 4);
            end
            if (phase == 1) begin
                iframe = 1'b0; iready = 1'($urandom_range(0, 1));
                left--;
                if (left == 0) phase = 2;
            end else if (phase == 2) begin
                iframe = 1'b1; iready = 1'b0; phase = 0;
            end else begin
                iframe = ($urandom_range(0, 31) != 0);
                iready = ($urandom_range(0, 15) != 0);
            end
            if (!rst_n) phase = 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
